// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: state, opcode, ALU and mux select encodings for the multicycle RV32I controller.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_JAL, S_ALUWB, S_BRANCH
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps {alu_op, op[5], funct3, funct7[5]} to an ALUCTRL_W-bit ALU code.
module mc_alu_decoder
   import riscv_mc_pkg::*;
#(
   parameter int ALUCTRL_W = 3
) (
   input  logic [1:0]           alu_op_i,
   input  logic                 op5_i,
   input  logic [2:0]           funct3_i,
   input  logic                 funct7_5_i,
   output logic [ALUCTRL_W-1:0] alu_control_o
);
   localparam bit EXT = (ALUCTRL_W == 4);
   logic [3:0] code;
   logic       unused_w;
   always_comb begin
      code = ALU_ADD;
      if (alu_op_i == ALUOP_SUB) code = ALU_SUB;
      else if (alu_op_i == ALUOP_FUNCT)
         case (funct3_i)
            3'b000:  code = (op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD;
            3'b010:  code = ALU_SLT;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            3'b100:  code = EXT ? ALU_XOR : ALU_ADD;
            3'b001:  code = EXT ? ALU_SLL : ALU_ADD;
            3'b101:  code = EXT ? (funct7_5_i ? ALU_SRA : ALU_SRL) : ALU_ADD;
            default: code = ALU_ADD;
         endcase
   end
   assign alu_control_o = code[ALUCTRL_W-1:0];
   assign unused_w = code[3];
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multicycle RV32I datapath.
// Define BRANCH_EXT_EN for full bne/blt/bge/bltu/bgeu branch decoding.
module multicycle_control_unit
   import riscv_mc_pkg::*;
#(
   parameter int ALUCTRL_W = 3,
   parameter int OPCODE_W  = 7
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [OPCODE_W-1:0]  op_i,
   input  logic [2:0]           funct3_i,
   input  logic [6:0]           funct7_i,
   input  logic                 zero_i,
   input  logic                 lt_i,
   input  logic                 ltu_i,
   output logic                 pc_write_o,
   output logic                 adr_src_o,
   output logic                 mem_write_o,
   output logic                 ir_write_o,
   output logic                 reg_write_o,
   output logic [1:0]           result_src_o,
   output logic [1:0]           alu_src_a_o,
   output logic [1:0]           alu_src_b_o,
   output logic [1:0]           imm_src_o,
   output logic [ALUCTRL_W-1:0] alu_control_o,
   output logic                 instr_done_o,
   output logic                 illegal_o
);
   state_e     state_q, state_d;
   logic [1:0] alu_op;
   logic       pc_upd, branch, mem_w, ir_w, reg_w, done, ill, taken, br_bad;
   logic       unused_w;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= S_FETCH;
      else         state_q <= state_d;

`ifdef BRANCH_EXT_EN
   always_comb begin
      taken  = 1'b0;
      br_bad = 1'b0;
      case (funct3_i)
         3'b000:  taken = zero_i;
         3'b001:  taken = !zero_i;
         3'b100:  taken = lt_i;
         3'b101:  taken = !lt_i;
         3'b110:  taken = ltu_i;
         3'b111:  taken = !ltu_i;
         default: br_bad = 1'b1;
      endcase
   end
   assign unused_w = ^{funct7_i[6], funct7_i[4:0]};
`else
   assign taken    = zero_i;
   assign br_bad   = 1'b0;
   assign unused_w = ^{lt_i, ltu_i, funct7_i[6], funct7_i[4:0]};
`endif

   always_comb begin
      state_d      = S_FETCH;
      adr_src_o    = 1'b0;
      result_src_o = RES_ALUOUT;
      alu_src_a_o  = SRCA_PC;
      alu_src_b_o  = SRCB_RS2;
      alu_op       = ALUOP_ADD;
      pc_upd       = 1'b0;
      branch       = 1'b0;
      mem_w        = 1'b0;
      ir_w         = 1'b0;
      reg_w        = 1'b0;
      done         = 1'b0;
      ill          = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_w         = 1'b1;
            pc_upd       = 1'b1;
            alu_src_b_o  = SRCB_FOUR;
            result_src_o = RES_ALURESULT;
            state_d      = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a_o = SRCA_OLDPC;
            alu_src_b_o = SRCB_IMM;
            if (op_i == OP_LW || op_i == OP_SW) state_d = S_MEMADR;
            else if (op_i == OP_R)              state_d = S_EXECUTER;
            else if (op_i == OP_I)              state_d = S_EXECUTEI;
            else if (op_i == OP_JAL)            state_d = S_JAL;
            else if (op_i == OP_BR)             state_d = S_BRANCH;
            else begin
               ill  = 1'b1;
               done = 1'b1;
            end
         end
         S_MEMADR: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            state_d     = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src_o = 1'b1;
            state_d   = S_MEMWB;
         end
         S_MEMWB: begin
            result_src_o = RES_DATA;
            reg_w        = 1'b1;
            done         = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src_o = 1'b1;
            mem_w     = 1'b1;
            done      = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a_o = SRCA_RS1;
            alu_op      = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            alu_op      = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_JAL: begin
            alu_src_a_o = SRCA_OLDPC;
            alu_src_b_o = SRCB_FOUR;
            pc_upd      = 1'b1;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w = 1'b1;
            done  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_o = SRCA_RS1;
            alu_op      = ALUOP_SUB;
            branch      = 1'b1;
            done        = 1'b1;
            ill         = br_bad;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Enables are gated by reset so nothing can pulse while rst_ni is low.
   assign pc_write_o   = rst_ni & (pc_upd | (branch & taken));
   assign mem_write_o  = rst_ni & mem_w;
   assign ir_write_o   = rst_ni & ir_w;
   assign reg_write_o  = rst_ni & reg_w;
   assign instr_done_o = rst_ni & done;
   assign illegal_o    = rst_ni & ill;

   assign imm_src_o = (op_i == OP_SW)  ? 2'b01 :
                      (op_i == OP_BR)  ? 2'b10 :
                      (op_i == OP_JAL) ? 2'b11 : 2'b00;

   mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
      .alu_op_i      (alu_op),
      .op5_i         (op_i[5]),
      .funct3_i      (funct3_i),
      .funct7_5_i    (funct7_i[5]),
      .alu_control_o (alu_control_o)
   );
endmodule
